code_sender: RTL and testbench

CODE_SENDER -- requirements
Module: code_sender

---
 rtl/code_sender.sv | 136 +++++++++++++
 tb/tb_code_sender.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_sender.sv
// Sends a stored digit code to a lock one digit per cycle, then waits a bounded
// time for the lock to open and reports the outcome as sticky pass/fail flags.
module code_sender #(
  parameter int                             NUM_DIGITS = 6,
  parameter int                             DIGIT_W    = 4,
  parameter logic [DIGIT_W-1:0]             IDLE_DIGIT = '0,
  parameter int                             TIMEOUT    = 4,
  // Digit k lives at bits [k*DIGIT_W +: DIGIT_W]; default code is 3,3,5,2,5,6.
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]  DEF_CODE   = 24'h652533
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               code_wr_en,
  input  logic [2:0]         code_wr_idx,
  input  logic [DIGIT_W-1:0] code_wr_data,
  input  logic               lock_locked,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]      IDX_END  = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic                 busy_q, done_q, pass_q, pass_d, fail_q, fail_d;
  logic [DIGIT_W-1:0]   code_q [NUM_DIGITS];
  logic                 wr_ok;

  assign wr_ok = (state_q == IDLE) && code_wr_en && !start && (code_wr_idx < IDX_END);

  always_comb begin
    // NOTE: combinational logic uses blocking assignments, and every variable gets
    // a default first so no path through the case can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE: begin
        digit_d = IDLE_DIGIT;
        if (start) begin
          if (lock_locked) begin
            digit_d = code_q[0];
            idx_d   = 3'd1;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            state_d = SEND;
          end else begin
            pass_d  = 1'b1;
            fail_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (idx_q < IDX_END) begin
          digit_d = code_q[idx_q];
          idx_d   = idx_q + 3'd1;
        end else begin
          digit_d = IDLE_DIGIT;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!lock_locked) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        digit_d = IDLE_DIGIT;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      digit_q <= IDLE_DIGIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      busy_q  <= (state_d == SEND) || (state_d == WAIT);
      done_q  <= (state_d == DONE);
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // NOTE: the code store must come back as DEF_CODE on reset, so it is built
  // from resettable flops rather than a RAM macro that cannot be reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) code_q[i] <= DEF_CODE[i*DIGIT_W +: DIGIT_W];
    end else if (wr_ok) begin
      code_q[code_wr_idx] <= code_wr_data;
    end
  end

  assign digit_out = digit_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_code_sender.sv
// Scoreboard bench for code_sender: a behavioural lock consumes digit_out and
// expected digits/outcomes are queued at start and checked as the DUT produces them.
module tb_code_sender;

  localparam int N = 6;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic         code_wr_en = 1'b0;
  logic [2:0]   code_wr_idx = '0;
  logic [W-1:0] code_wr_data = '0;
  logic         lock_locked;
  logic [W-1:0] digit_out;
  logic         busy, done, pass, fail;

  always #5 clk = ~clk;

  code_sender dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .code_wr_en   (code_wr_en),
    .code_wr_idx  (code_wr_idx),
    .code_wr_data (code_wr_data),
    .lock_locked  (lock_locked),
    .digit_out    (digit_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail)
  );

  int def_code [N] = '{3, 3, 5, 2, 5, 6};
  int secret   [N] = '{3, 3, 5, 2, 5, 6};
  int model_code [N];

  // Lock: opens after seeing the secret on N consecutive sampled digits.
  int prog = 0;
  bit opened = 1'b0;
  bit lock_clr = 1'b0;
  bit force_open = 1'b0;
  always @(posedge clk) begin
    if (lock_clr) begin
      prog   <= 0;
      opened <= 1'b0;
    end else if (!opened) begin
      if (int'(digit_out) == secret[prog]) begin
        if (prog == N - 1) opened <= 1'b1;
        prog <= (prog == N - 1) ? 0 : prog + 1;
      end else begin
        prog <= 0;
      end
    end
  end
  assign lock_locked = !(opened || force_open);

  typedef struct {
    bit pass;
    bit fail;
    int done_cyc;
  } res_t;

  int   exp_digit_q [$];
  res_t res_q [$];
  res_t r_mon;
  int   cyc = 0;
  int   c_mon = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: digits while busy, then the idle digit, then the outcome on done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) begin
        if (c_mon < N) begin
          check("digit_expected", exp_digit_q.size() != 0, 1);
          if (exp_digit_q.size() != 0) check("digit", digit_out, exp_digit_q.pop_front());
        end else if (c_mon == N) begin
          check("digit_after_seq", digit_out, 0);
        end
        c_mon++;
      end else begin
        c_mon = 0;
      end
      if (done) begin
        check("result_expected", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          r_mon = res_q.pop_front();
          check("pass", pass, r_mon.pass);
          check("fail", fail, r_mon.fail);
          check("done_cycle", cyc, r_mon.done_cyc);
          check("done_busy", busy, 0);
          check("done_digit", digit_out, 0);
        end
      end
    end else begin
      c_mon = 0;
    end
  end

  task automatic lock_clear();
    @(negedge clk) lock_clr = 1'b1;
    @(negedge clk) lock_clr = 1'b0;
  endtask

  task automatic write_code(input logic [2:0] idx, input logic [W-1:0] data, input bit legal);
    @(negedge clk);
    code_wr_en = 1'b1;
    code_wr_idx = idx;
    code_wr_data = data;
    @(negedge clk);
    code_wr_en = 1'b0;
    if (legal) model_code[idx] = int'(data);
  endtask

  // Drives start for one edge and queues what that accepted start must produce.
  task automatic start_seq(input int lat, input bit ep, input bit ef, input bit digits,
                           input bit wr0, input bit rel);
    res_t r;
    @(negedge clk);
    if (rel) reset_n = 1'b1;
    start = 1'b1;
    if (wr0) begin
      code_wr_en = 1'b1;
      code_wr_idx = 3'd0;
      code_wr_data = 4'd9;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    code_wr_en = 1'b0;
    if (digits) for (int i = 0; i < N; i++) exp_digit_q.push_back(model_code[i]);
    r.pass = ep;
    r.fail = ef;
    r.done_cyc = cyc + lat;
    res_q.push_back(r);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) model_code[i] = def_code[i];

    // Reset state, asserted asynchronously before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check("rst_digit", digit_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Default code opens the lock.
    lock_clear();
    start_seq(7, 1, 0, 1, 0, 0);
    wait_done();

    // Modified digit keeps the lock shut until timeout.
    write_code(3'd2, 4'd4, 1);
    check("pass_sticky", pass, 1);
    lock_clear();
    start_seq(10, 0, 1, 1, 0, 0);
    check("pass_cleared", pass, 0);
    wait_done();

    // Lock already open: no digits, immediate done.
    force_open = 1'b1;
    start_seq(0, 1, 0, 0, 0, 0);
    check("open_busy", busy, 0);
    check("open_digit", digit_out, 0);
    wait_done();
    force_open = 1'b0;

    // start during SEND and a write during WAIT are both ignored.
    lock_clear();
    start_seq(10, 0, 1, 1, 0, 0);
    @(negedge clk);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    code_wr_en = 1'b1;
    code_wr_idx = 3'd0;
    code_wr_data = 4'd9;
    @(negedge clk) code_wr_en = 1'b0;
    wait_done();
    write_code(3'd6, 4'd9, 0);
    lock_clear();
    start_seq(10, 0, 1, 1, 0, 0);
    wait_done();

    // Reset during the third digit aborts the sequence and restores the code.
    lock_clear();
    start_seq(10, 0, 1, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("pre_rst_digit2", digit_out, model_code[2]);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_digit", digit_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fail", fail, 0);
    check("mid_rst_done", done, 0);
    exp_digit_q.delete();
    res_q.delete();
    for (int i = 0; i < N; i++) model_code[i] = def_code[i];
    lock_clear();
    start_seq(7, 1, 0, 1, 0, 1);
    wait_done();

    // Write coinciding with start is discarded.
    lock_clear();
    start_seq(7, 1, 0, 1, 1, 0);
    wait_done();

    check("sb_digits_drained", exp_digit_q.size(), 0);
    check("sb_results_drained", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
